quad_sequencer: RTL

- Top-level sequencer for the quadrant convolution datapath (quad_module instance).
- On a start pulse, runs the four quadrant passes in order 0..3. For each pass it:
  - drives the origin, sub-quadrant and mask configuration;
  - pulses the slave reset;
  - holds quad_enable until quad_finish;
  - drains the 3-stage MAC pipeline.
- Gates scratchpad write enables, counts writes per pass, and flags protocol errors (watchdog timeout, write-count mismatch) back to the top.

---
 rtl/quad_sequencer_if.sv | 24 ++
 rtl/quad_sequencer.sv | 69 ++++++
 2 files changed

// File: rtl/quad_sequencer_if.sv
// quad_sequencer_if: sequencer <-> quad_module control, config and scratchpad strobes
interface quad_sequencer_if;
   logic       quad_reset;
   logic       quad_enable;
   logic       quad_finish;
   logic       sp_data_rdy;
   logic       sp_wen;
   logic [3:0] quad_a_x_origin;
   logic [3:0] quad_a_y_origin;
   logic       sp_x_mask;
   logic       sp_y_mask;
   logic [3:0] quad_a_x_mask;
   logic [3:0] quad_a_y_mask;
   modport master (
      output quad_reset, quad_enable, sp_wen, quad_a_x_origin, quad_a_y_origin,
             sp_x_mask, sp_y_mask, quad_a_x_mask, quad_a_y_mask,
      input  quad_finish, sp_data_rdy
   );
   modport slave (
      input  quad_reset, quad_enable, sp_wen, quad_a_x_origin, quad_a_y_origin,
             sp_x_mask, sp_y_mask, quad_a_x_mask, quad_a_y_mask,
      output quad_finish, sp_data_rdy
   );
endinterface

// File: rtl/quad_sequencer.sv
// quad_sequencer: runs four quadrant passes with write gating, watchdog and write-count check
module quad_sequencer #(
   parameter int DRAIN_CYCLES = 4,
   parameter int TIMEOUT      = 1023,
   parameter int EXP_WR       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [1:0]       quad_idx,
   output logic [4:0]       wr_count,
   quad_sequencer_if.master q
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, NEXT, FIN, ERR} state_t;
   state_t     state, state_n;
   logic [1:0] idx_n, cfg_n;
   logic [3:0] drain;
   logic [9:0] wdog;
   always_comb begin
      state_n = state;
      idx_n   = quad_idx;
      case (state)
         IDLE:    if (start) begin state_n = LOAD; idx_n = 2'd0; end
         LOAD:    state_n = RUN;
         RUN:     state_n = q.quad_finish ? DRAIN : wdog == 10'(TIMEOUT - 1) ? ERR : RUN;
         DRAIN:   if (drain == 4'd0) state_n = wr_count != 5'(EXP_WR) ? ERR : NEXT;
         NEXT:    if (quad_idx == 2'd3) state_n = FIN; else begin state_n = LOAD; idx_n = quad_idx + 2'd1; end
         default: state_n = IDLE;
      endcase
      // config follows the upcoming pass so it is already valid in LOAD; IDLE shows quad 0
      cfg_n           = state_n == IDLE ? 2'd0 : idx_n;
      busy            = state != IDLE;
      done            = state == FIN || state == ERR;
      q.quad_reset    = reset || state == LOAD;
      q.quad_enable   = state == RUN;
      q.sp_wen        = q.sp_data_rdy && (state == RUN || state == DRAIN);
      q.quad_a_x_mask = 4'b1010;
      q.quad_a_y_mask = 4'b1001;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         quad_idx          <= 2'd0;
         wr_count          <= 5'd0;
         drain             <= 4'd0;
         wdog              <= 10'd0;
         error             <= 1'b0;
         q.quad_a_x_origin <= 4'd0;
         q.quad_a_y_origin <= 4'd0;
         q.sp_x_mask       <= 1'b0;
         q.sp_y_mask       <= 1'b0;
      end else begin
         state             <= state_n;
         quad_idx          <= idx_n;
         wdog              <= state == RUN ? wdog + 10'd1 : 10'd0;
         drain             <= state == RUN ? 4'(DRAIN_CYCLES - 1) : state == DRAIN ? drain - 4'd1 : drain;
         error             <= state_n == ERR ? 1'b1 : state == IDLE && start ? 1'b0 : error;
         wr_count          <= (state == IDLE && start) || (state == NEXT && state_n == LOAD) ? 5'd0 :
                              q.sp_wen && wr_count != 5'd31 ? wr_count + 5'd1 : wr_count;
         q.quad_a_x_origin <= cfg_n[0] ? 4'd6 : 4'd0;
         q.quad_a_y_origin <= cfg_n[1] ? 4'd6 : 4'd0;
         q.sp_x_mask       <= cfg_n[0];
         q.sp_y_mask       <= cfg_n[1];
      end
   end
endmodule
